// File: rtl/phase_gen_if.sv
// phase_gen_if: burst request and phase-sample bus of phase_gen.
//   i_start/i_phase0/i_step/i_nsamp : burst request (requester -> generator)
//   o_phase/o_valid/o_last/o_busy   : phase samples and status (generator -> sincos)
// master = requester side, slave = phase_gen.
interface phase_gen_if #(
  parameter int PW = 16,
  parameter int CW = 16
);
  logic                 i_start;
  logic signed [PW-1:0] i_phase0;
  logic signed [PW-1:0] i_step;
  logic        [CW-1:0] i_nsamp;
  logic signed [PW-1:0] o_phase;
  logic                 o_valid;
  logic                 o_last;
  logic                 o_busy;

  modport master (
    output i_start, i_phase0, i_step, i_nsamp,
    input  o_phase, o_valid, o_last, o_busy
  );

  modport slave (
    input  i_start, i_phase0, i_step, i_nsamp,
    output o_phase, o_valid, o_last, o_busy
  );
endinterface

// File: rtl/phase_gen.sv
// phase_gen: emits a burst of i_nsamp phase samples, one per clock, starting at
// wrap(i_phase0) and advancing by sat(i_step). Phase is A(2,PW-3) radians kept
// in [-PI_Q, PI_Q). Feeds the sincos CORDIC stage directly.
// Ports:
//   i_clk  : clock
//   i_rstn : synchronous active-low reset
//   bus    : phase_gen_if.slave (start/phase0/step/nsamp in, phase/valid/last/busy out)
module phase_gen #(
  parameter int PW   = 16,
  parameter int CW   = 16,
  parameter int PI_Q = 25736
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  phase_gen_if.slave   bus
);
  // Wrap arithmetic runs one bit wider so phase+step (up to +-2*pi) never overflows.
  localparam logic signed [PW:0] PI_X   = (PW+1)'(PI_Q);
  localparam logic signed [PW:0] TWO_PI = (PW+1)'(2*PI_Q);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic                 load;
  logic signed [PW-1:0] phase_r, step_r;
  logic        [CW-1:0] cnt_r;
  logic signed [PW:0]   sum;

  // Single fold is exact: inputs are within +-2*pi of the target range.
  function automatic logic signed [PW-1:0] wrap(input logic signed [PW:0] s);
    logic signed [PW:0] r;
    if (s >= PI_X)       r = s - TWO_PI;
    else if (s < -PI_X)  r = s + TWO_PI;
    else                 r = s;
    return r[PW-1:0];
  endfunction

  // Clamping |step| to pi is what keeps the single-fold wrap exact.
  function automatic logic signed [PW-1:0] sat(input logic signed [PW-1:0] x);
    logic signed [PW:0] xe;
    xe = {x[PW-1], x};
    if (xe > PI_X)       xe = PI_X;
    else if (xe < -PI_X) xe = -PI_X;
    return xe[PW-1:0];
  endfunction

  assign sum = {phase_r[PW-1], phase_r} + {step_r[PW-1], step_r};

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (bus.i_start && bus.i_nsamp != '0) begin
        state_nxt = RUN;
        load      = 1'b1;
      end
      RUN:  if (cnt_r == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      phase_r <= '0;
      step_r  <= '0;
      cnt_r   <= '0;
    end else if (load) begin
      phase_r <= wrap({bus.i_phase0[PW-1], bus.i_phase0});
      step_r  <= sat(bus.i_step);
      cnt_r   <= bus.i_nsamp;
    end else if (state == RUN) begin
      phase_r <= wrap(sum);
      cnt_r   <= cnt_r - CW'(1);
    end
  end

  // All outputs decode registered state only; no input-to-output path.
  assign bus.o_phase = phase_r;
  assign bus.o_valid = (state == RUN);
  assign bus.o_busy  = (state == RUN);
  assign bus.o_last  = (state == RUN) && (cnt_r == CW'(1));
endmodule

// File: doc/phase_gen.md
Name: phase_gen

Overview:
- Phase generator that sits directly upstream of the sincos CORDIC stage.
- Produces a burst of N phase samples, one per clock, starting at a programmed initial phase and advancing by a programmed step.
- Output phase is in radians, fixed-point A(2,f): sign bit, 2 integer bits, PW-3 fractional bits.
- The phase wraps so it always lies in [-pi, +pi). The o_phase/o_valid pair connects directly to the sincos phase and valid inputs.

Parameters:
- PW, 16: phase width in bits; fractional bits = PW-3.
- CW, 16: width of the sample-count input.
- PI_Q, 25736: pi in phase units, round(pi*2^(PW-3)); 25736 for PW=16.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  reset; synchronous, active-low.
- i_start  input  1  one-cycle burst request; sampled only in IDLE.
- i_phase0  input  PW  signed initial phase, A(2,f).
- i_step  input  PW  signed phase increment per sample, A(2,f).
- i_nsamp  input  CW  number of samples in the burst (unsigned).
- o_phase  output  PW  signed phase sample, A(2,f), always in [-PI_Q, PI_Q-1].
- o_valid  output  1  high when o_phase holds a valid sample.
- o_last  output  1  high together with o_valid on the final sample of a burst.
- o_busy  output  1  high while a burst is in progress.

Behaviour:
- Reset: one clock edge with i_rstn=0 forces state IDLE. It also forces o_phase=0, o_valid=0, o_last=0, o_busy=0, and clears the internal counters and registers.
- Reset takes priority over all other inputs. A reset during a burst aborts it; no further valid samples are produced.
- FSM has two states, IDLE and RUN.
- IDLE -> RUN: on i_start=1 with i_nsamp != 0.
  - On that edge, latch step_r = sat(i_step) and phase_r = wrap(i_phase0); load the remaining count with i_nsamp.
  - o_busy goes high on the same edge.
- i_start with i_nsamp=0: ignored; the block stays in IDLE with no outputs.
- i_start while in RUN: ignored. New parameters are not latched.
- RUN, every cycle:
  - o_valid=1, and o_phase is the registered phase_r.
  - Update phase_r = wrap(phase_r + step_r) and decrement the count.
  - When the count reaches 1: o_last=1, then return to IDLE. On the next edge o_valid, o_last and o_busy drop to 0.
- Latency: the first sample appears in the cycle after the i_start edge (1-cycle latency). Samples are back-to-back with no gaps; there is no backpressure.
- Burst length: exactly i_nsamp valid cycles. The maximum is 2^CW-1.
- Arithmetic:
  - Compute s = phase_r + step_r at PW+1 bits, signed.
  - wrap(s): if s >= PI_Q, s - 2*PI_Q; else if s < -PI_Q, s + 2*PI_Q; else s. Then truncate to PW bits.
  - This is always exact because |step_r| <= PI_Q.
- sat(x): clamp to [-PI_Q, PI_Q].
- wrap(i_phase0): applied once at load, so an out-of-range initial phase maps into [-PI_Q, PI_Q).
- Boundaries: +PI_Q is never output; it maps to -PI_Q. -PI_Q is a legal output.
- Outputs are registered, with no combinational path from inputs to outputs.
- A new i_start is accepted in the same cycle that o_busy is observed low. Throughput is one burst, then at least one idle cycle.

Test Plan:
- Positive wrap: phase0=0, step=8192, nsamp=5 -> o_phase = 0, 8192, 16384, 24576, -18704. o_last on the 5th sample, then o_busy=0.
- Negative wrap: phase0=0, step=-8192, nsamp=5 -> 0, -8192, -16384, -24576, 18704.
- Step at limit: step=25736, phase0=0, nsamp=4 -> 0, -25736, 0, -25736. Then step=30000 -> saturated; output equals the step=25736 case.
- Length edge cases:
  - nsamp=0 -> no o_valid, o_busy stays 0.
  - nsamp=1 -> a single sample with o_valid=o_last=1.
  - i_start pulsed mid-burst -> burst length and values unchanged.
- Reset: i_rstn=0 at sample 3 of a 10-sample burst -> next cycle o_valid=o_busy=o_phase=0, and no further samples. A following start works normally.
- Init wrap: phase0=30000 -> first sample is -21472. Then pipe o_phase to sincos and check sin/cos against a reference model within 2 LSB.
